mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Parametrised load/store unit for the rv32i memory stage.
- Replaces the single-cycle, read-modify-write memory access with a handshaked bus master that writes through byte enables.
- Tolerates multi-cycle memory, detects misaligned accesses, bus errors and bus timeouts, and stalls the pipeline while an access is outstanding.
- Sits between the exe_mem register and the mem_wb register, and drives the data-memory bus.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 16, maximum cycles in BUS without an ack before a timeout exception; legal range 1..255.
- HALT_ADDR, 32'h0000_1000, store address that signals end of test (used only with the optional feature).

Ports:
- clk_in  in  1  clock, rising edge.
- reset_n_in  in  1  asynchronous, active-low reset.
- req_valid_in  in  1  exe_mem holds a valid instruction.
- req_ready_out  out  1  unit can accept the instruction this cycle.
- mem_op_in  in  4  LB/LH/LW/LBU/LHU/SB/SH/SW codes from defines.v; any other code means non-memory.
- mem_addr_in  in  ADDR_WIDTH  effective byte address.
- mem_data_in  in  32  store data, right-aligned.
- reg_waddr_in  in  5  destination register.
- reg_wdata_in  in  32  ALU result for non-memory ops.
- reg_we_in  in  1  register write enable.
- stall_out  out  1  freeze upstream stages; equal to ~req_ready_out.
- bus_req_out  out  1  bus request, held until ack/err/timeout.
- bus_we_out  out  1  1 = write.
- bus_addr_out  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2],2'b00}.
- bus_wdata_out  out  32  store lane data.
- bus_be_out  out  4  byte enables.
- bus_ack_in  in  1  access complete; rdata valid.
- bus_err_in  in  1  access failed.
- bus_rdata_in  in  32  read word.
- wb_valid_out  out  1  one-cycle pulse; result valid.
- reg_waddr_out  out  5  writeback address.
- reg_wdata_out  out  32  writeback data.
- reg_we_out  out  1  writeback enable.
- exc_valid_out  out  1  one-cycle exception pulse.
- exc_cause_out  out  2  0 load misaligned, 1 store misaligned, 2 bus error, 3 timeout.
- exc_addr_out  out  ADDR_WIDTH  faulting byte address.
- halt_out  out  1  sticky end-of-test flag.

Behaviour:
- Reset (asynchronous, reset_n_in=0):
  - state=IDLE, timeout counter=0.
  - All outputs 0, except req_ready_out=1 after release.
  - bus_req_out drops immediately; an abandoned bus cycle is legal.
- FSM states: IDLE, BUS.
  - req_ready_out=1 only in IDLE.
  - An instruction is accepted on a cycle with req_valid_in & req_ready_out.
- Non-memory op accepted at cycle N:
  - wb_valid_out=1 at N+1 with the registered waddr, wdata and we.
  - State stays IDLE, so throughput is one instruction per cycle.
- Alignment check at accept:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Byte ops are always aligned.
- Misaligned access at N:
  - No bus request.
  - At N+1: exc_valid_out=1, cause 0 or 1, exc_addr_out=mem_addr_in, wb_valid_out=1, reg_we_out=0.
- Aligned memory op at N:
  - Latch op, offset, waddr and store lanes; enter BUS.
  - bus_req_out=1 from N+1 until termination; bus outputs stable while requested.
- Store lanes:
  - SB: wdata = data[7:0] replicated 4x, be = 4'b0001 << off.
  - SH: wdata = data[15:0] replicated 2x, be = 4'b0011 << off.
  - SW: be = 4'b1111.
  - Loads: bus_we_out=0, be=4'b1111.
- Termination cycle T (ack, err, or counter reaching TIMEOUT_CYCLES):
  - At T+1: state=IDLE, bus_req_out=0, wb_valid_out=1.
  - Loads: reg_wdata_out = lane rdata[8*off+:8] or rdata[8*off+:16], sign-extended for LB/LH, zero-extended for LBU/LHU; LW passes the word.
  - reg_we_out = latched we for loads, 0 for stores.
- Priority in the same cycle: err > ack > timeout.
  - err or timeout produces exc_valid_out with cause 2 or 3 and reg_we_out=0.
- Timeout counter:
  - Cleared on entering BUS; increments each BUS cycle without ack/err.
  - Timeout fires on the cycle the counter equals TIMEOUT_CYCLES-1.
- wb_valid_out and exc_valid_out are single-cycle pulses; there is no backpressure from mem_wb.
- Inputs are ignored while in BUS.

Optional Feature:
- Macro: MEM_LSU_HALT_DETECT_EN.
- Defined: halt_out sets to 1 on the cycle after an SW to HALT_ADDR terminates with ack, then stays 1 until reset. The store is still performed on the bus.
- Undefined: halt_out is tied to 0 and no comparator is built.

Test Plan:
- Non-memory ops streamed 3 back-to-back -> wb_valid_out pulses at N+1..N+3 with the matching wdata; req_ready_out stays 1.
- LB addr 0x103, bus ack 2 cycles later with rdata 0x80FF_1234 -> bus_addr_out 0x100, reg_wdata_out 0xFFFF_FF80, stall_out high for 3 cycles.
- SH addr 0x202, data 0x0000_ABCD, ack immediately -> bus_be_out 4'b1100, bus_wdata_out 0xABCD_ABCD, reg_we_out 0.
- LW addr 0x105 -> no bus_req_out; exc cause 0, exc_addr_out 0x105 at N+1.
- LW with no ack, TIMEOUT_CYCLES=4 -> bus_req_out high 4 cycles, then exc cause 3; err and ack asserted together -> cause 2.
- reset_n_in low mid-BUS -> bus_req_out 0 immediately; SW to HALT_ADDR with the macro defined -> halt_out=1 and sticky.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: rv32i memory-stage load/store unit acting as a handshaked bus master.
// Non-memory ops pass through in one cycle; aligned loads/stores run a bus
// cycle that ends on ack, err or timeout; misaligned accesses raise an
// exception without touching the bus.
//
// Optional feature macro: MEM_LSU_HALT_DETECT_EN (sticky halt_out on an
// acknowledged SW to HALT_ADDR). When undefined, halt_out is tied to 0.
//
// Ports:
//   clk_in, reset_n_in             clock, async active-low reset
//   req_valid_in / req_ready_out   accept handshake from exe_mem
//   mem_op_in, mem_addr_in, mem_data_in, reg_waddr_in, reg_wdata_in, reg_we_in
//                                  instruction fields from exe_mem
//   stall_out                      upstream freeze (~req_ready_out)
//   bus_*                          data-memory bus master
//   wb_valid_out, reg_w*_out       writeback pulse to mem_wb
//   exc_valid_out, exc_cause_out, exc_addr_out  exception pulse
//   halt_out                       sticky end-of-test flag
module mem_lsu #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 16,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = ADDR_WIDTH'(32'h0000_1000)
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [3:0]            mem_op_in,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [31:0]           mem_data_in,
  input  logic [4:0]            reg_waddr_in,
  input  logic [31:0]           reg_wdata_in,
  input  logic                  reg_we_in,
  output logic                  stall_out,
  output logic                  bus_req_out,
  output logic                  bus_we_out,
  output logic [ADDR_WIDTH-1:0] bus_addr_out,
  output logic [31:0]           bus_wdata_out,
  output logic [3:0]            bus_be_out,
  input  logic                  bus_ack_in,
  input  logic                  bus_err_in,
  input  logic [31:0]           bus_rdata_in,
  output logic                  wb_valid_out,
  output logic [4:0]            reg_waddr_out,
  output logic [31:0]           reg_wdata_out,
  output logic                  reg_we_out,
  output logic                  exc_valid_out,
  output logic [1:0]            exc_cause_out,
  output logic [ADDR_WIDTH-1:0] exc_addr_out,
  output logic                  halt_out
);

  // Memory opcodes (shared encoding with the decoder defines)
  localparam logic [3:0] OP_LB  = 4'h1;
  localparam logic [3:0] OP_LH  = 4'h2;
  localparam logic [3:0] OP_LW  = 4'h3;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h6;
  localparam logic [3:0] OP_SH  = 4'h7;
  localparam logic [3:0] OP_SW  = 4'h8;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_LD_MIS = 2'd0;
  localparam logic [1:0] CAUSE_ST_MIS = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR = 2'd2;
  localparam logic [1:0] CAUSE_TMO    = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [3:0]            r_op, w_op_nxt;
  logic [1:0]            r_off, w_off_nxt;
  logic [4:0]            r_waddr, w_waddr_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;

  logic                  r_ready, w_ready_nxt;
  logic                  r_stall, w_stall_nxt;
  logic                  r_bus_req, w_bus_req_nxt;
  logic                  r_bus_we, w_bus_we_nxt;
  logic [ADDR_WIDTH-1:0] r_bus_addr, w_bus_addr_nxt;
  logic [31:0]           r_bus_wdata, w_bus_wdata_nxt;
  logic [3:0]            r_bus_be, w_bus_be_nxt;
  logic                  r_wb_valid, w_wb_valid_nxt;
  logic [4:0]            r_reg_waddr, w_reg_waddr_nxt;
  logic [31:0]           r_reg_wdata, w_reg_wdata_nxt;
  logic                  r_reg_we, w_reg_we_nxt;
  logic                  r_exc_valid, w_exc_valid_nxt;
  logic [1:0]            r_exc_cause, w_exc_cause_nxt;
  logic [ADDR_WIDTH-1:0] r_exc_addr, w_exc_addr_nxt;

  // Opcode decode on the incoming instruction
  logic w_is_load, w_is_store, w_misaligned;
  always_comb begin
    w_is_load    = (mem_op_in == OP_LB) || (mem_op_in == OP_LH) || (mem_op_in == OP_LW) ||
                   (mem_op_in == OP_LBU) || (mem_op_in == OP_LHU);
    w_is_store   = (mem_op_in == OP_SB) || (mem_op_in == OP_SH) || (mem_op_in == OP_SW);
    w_misaligned = (((mem_op_in == OP_LH) || (mem_op_in == OP_LHU) || (mem_op_in == OP_SH))
                    && mem_addr_in[0]) ||
                   (((mem_op_in == OP_LW) || (mem_op_in == OP_SW)) && (mem_addr_in[1:0] != 2'b00));
  end

  // Load lane extraction from the returned word
  logic [31:0] w_shift, w_load_data;
  always_comb begin
    w_shift = bus_rdata_in >> {r_off, 3'b000};
    case (r_op)
      OP_LB:   w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      OP_LBU:  w_load_data = {24'd0, w_shift[7:0]};
      OP_LH:   w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      OP_LHU:  w_load_data = {16'd0, w_shift[15:0]};
      default: w_load_data = bus_rdata_in;
    endcase
  end

  logic w_r_is_load;
  assign w_r_is_load = (r_op == OP_LB) || (r_op == OP_LH) || (r_op == OP_LW) ||
                       (r_op == OP_LBU) || (r_op == OP_LHU);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_op_nxt        = r_op;
    w_off_nxt       = r_off;
    w_waddr_nxt     = r_waddr;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_bus_req_nxt   = r_bus_req;
    w_bus_we_nxt    = r_bus_we;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wdata_nxt = r_bus_wdata;
    w_bus_be_nxt    = r_bus_be;
    w_wb_valid_nxt  = 1'b0;
    w_reg_waddr_nxt = r_reg_waddr;
    w_reg_wdata_nxt = r_reg_wdata;
    w_reg_we_nxt    = r_reg_we;
    w_exc_valid_nxt = 1'b0;
    w_exc_cause_nxt = r_exc_cause;
    w_exc_addr_nxt  = r_exc_addr;

    case (r_state)
      S_IDLE: begin
        if (req_valid_in) begin
          if (!w_is_load && !w_is_store) begin
            w_wb_valid_nxt  = 1'b1;
            w_reg_waddr_nxt = reg_waddr_in;
            w_reg_wdata_nxt = reg_wdata_in;
            w_reg_we_nxt    = reg_we_in;
          end else if (w_misaligned) begin
            w_wb_valid_nxt  = 1'b1;
            w_reg_waddr_nxt = reg_waddr_in;
            w_reg_wdata_nxt = 32'd0;
            w_reg_we_nxt    = 1'b0;
            w_exc_valid_nxt = 1'b1;
            w_exc_cause_nxt = w_is_store ? CAUSE_ST_MIS : CAUSE_LD_MIS;
            w_exc_addr_nxt  = mem_addr_in;
          end else begin
            w_state_nxt    = S_BUS;
            w_cnt_nxt      = '0;
            w_op_nxt       = mem_op_in;
            w_off_nxt      = mem_addr_in[1:0];
            w_waddr_nxt    = reg_waddr_in;
            w_we_nxt       = reg_we_in;
            w_addr_nxt     = mem_addr_in;
            w_bus_req_nxt  = 1'b1;
            w_bus_we_nxt   = w_is_store;
            w_bus_addr_nxt = {mem_addr_in[ADDR_WIDTH-1:2], 2'b00};
            case (mem_op_in)
              OP_SB: begin
                w_bus_wdata_nxt = {4{mem_data_in[7:0]}};
                w_bus_be_nxt    = 4'b0001 << mem_addr_in[1:0];
              end
              OP_SH: begin
                w_bus_wdata_nxt = {2{mem_data_in[15:0]}};
                w_bus_be_nxt    = 4'b0011 << mem_addr_in[1:0];
              end
              OP_SW: begin
                w_bus_wdata_nxt = mem_data_in;
                w_bus_be_nxt    = 4'b1111;
              end
              default: begin
                w_bus_wdata_nxt = 32'd0;
                w_bus_be_nxt    = 4'b1111;
              end
            endcase
          end
        end
      end
      S_BUS: begin
        if (bus_err_in || bus_ack_in || (r_cnt == CNT_LAST)) begin
          w_state_nxt     = S_IDLE;
          w_bus_req_nxt   = 1'b0;
          w_wb_valid_nxt  = 1'b1;
          w_reg_waddr_nxt = r_waddr;
          w_reg_wdata_nxt = 32'd0;
          w_reg_we_nxt    = 1'b0;
          w_exc_addr_nxt  = r_addr;
          // err outranks ack, ack outranks timeout
          if (bus_err_in) begin
            w_exc_valid_nxt = 1'b1;
            w_exc_cause_nxt = CAUSE_BUSERR;
          end else if (bus_ack_in) begin
            if (w_r_is_load) begin
              w_reg_wdata_nxt = w_load_data;
              w_reg_we_nxt    = r_we;
            end
          end else begin
            w_exc_valid_nxt = 1'b1;
            w_exc_cause_nxt = CAUSE_TMO;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_stall_nxt = ~w_ready_nxt;
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= 4'd0;
      r_off       <= 2'd0;
      r_waddr     <= 5'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_ready     <= 1'b1;
      r_stall     <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= 32'd0;
      r_bus_be    <= 4'd0;
      r_wb_valid  <= 1'b0;
      r_reg_waddr <= 5'd0;
      r_reg_wdata <= 32'd0;
      r_reg_we    <= 1'b0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= 2'd0;
      r_exc_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op        <= w_op_nxt;
      r_off       <= w_off_nxt;
      r_waddr     <= w_waddr_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_ready     <= w_ready_nxt;
      r_stall     <= w_stall_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_bus_be    <= w_bus_be_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_reg_waddr <= w_reg_waddr_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_reg_we    <= w_reg_we_nxt;
      r_exc_valid <= w_exc_valid_nxt;
      r_exc_cause <= w_exc_cause_nxt;
      r_exc_addr  <= w_exc_addr_nxt;
    end
  end

`ifdef MEM_LSU_HALT_DETECT_EN
  // Sticky halt on an acknowledged (error-free) SW to HALT_ADDR
  logic r_halt;
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_halt <= 1'b0;
    end else if ((r_state == S_BUS) && bus_ack_in && !bus_err_in &&
                 (r_op == OP_SW) && (r_addr == HALT_ADDR)) begin
      r_halt <= 1'b1;
    end
  end
  assign halt_out = r_halt;
`else
  logic [ADDR_WIDTH-1:0] w_unused_halt_addr;
  assign w_unused_halt_addr = HALT_ADDR;
  assign halt_out = 1'b0;
`endif

  assign req_ready_out = r_ready;
  assign stall_out     = r_stall;
  assign bus_req_out   = r_bus_req;
  assign bus_we_out    = r_bus_we;
  assign bus_addr_out  = r_bus_addr;
  assign bus_wdata_out = r_bus_wdata;
  assign bus_be_out    = r_bus_be;
  assign wb_valid_out  = r_wb_valid;
  assign reg_waddr_out = r_reg_waddr;
  assign reg_wdata_out = r_reg_wdata;
  assign reg_we_out    = r_reg_we;
  assign exc_valid_out = r_exc_valid;
  assign exc_cause_out = r_exc_cause;
  assign exc_addr_out  = r_exc_addr;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu: table of single-cycle vectors plus
// hand-written bus sequences (latency, lanes, timeout, error, reset, halt).
module tb_mem_lsu;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LB  = 4'h1;
  localparam logic [3:0] OP_LH  = 4'h2;
  localparam logic [3:0] OP_LW  = 4'h3;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h6;
  localparam logic [3:0] OP_SH  = 4'h7;
  localparam logic [3:0] OP_SW  = 4'h8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  mem_op = 4'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_data = 32'd0;
  logic [4:0]  waddr_in = 5'd0;
  logic [31:0] wdata_in = 32'd0;
  logic        we_in = 1'b0;
  logic        stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        wb_valid;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out;
  logic        we_out;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;
  logic        halt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .HALT_ADDR(32'h0000_1000)) dut (
    .clk_in(clk), .reset_n_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .mem_op_in(mem_op), .mem_addr_in(mem_addr), .mem_data_in(mem_data),
    .reg_waddr_in(waddr_in), .reg_wdata_in(wdata_in), .reg_we_in(we_in),
    .stall_out(stall),
    .bus_req_out(bus_req), .bus_we_out(bus_we), .bus_addr_out(bus_addr),
    .bus_wdata_out(bus_wdata), .bus_be_out(bus_be),
    .bus_ack_in(bus_ack), .bus_err_in(bus_err), .bus_rdata_in(bus_rdata),
    .wb_valid_out(wb_valid), .reg_waddr_out(waddr_out), .reg_wdata_out(wdata_out),
    .reg_we_out(we_out), .exc_valid_out(exc_valid), .exc_cause_out(exc_cause),
    .exc_addr_out(exc_addr), .halt_out(halt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] wa);
    req_valid = 1'b1;
    mem_op    = op;
    mem_addr  = addr;
    mem_data  = data;
    waddr_in  = wa;
    wdata_in  = 32'h0;
    we_in     = 1'b1;
    tick();
    req_valid = 1'b0;
    mem_op    = OP_NOP;
  endtask

  // Load with an ack in the first bus cycle
  task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd,
                         input logic [31:0] exp, input string name);
    issue(op, addr, 32'h0, 5'd9);
    chk({name, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
    chk({name, " bus_we"}, 32'(bus_we), 32'd0);
    chk({name, " bus_be"}, 32'(bus_be), 32'hF);
    bus_ack = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    chk({name, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({name, " wdata"}, wdata_out, exp);
    chk({name, " we"}, 32'(we_out), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] alu;
    logic [4:0]  wa;
    logic        we;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        exp_exc;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n_req;
    logic exp_halt;

    vecs[0] = '{OP_NOP, 32'h0,   32'h1111_1111, 5'd1, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 2'd0};
    vecs[1] = '{4'hF,   32'h0,   32'h2222_2222, 5'd2, 1'b1, 1'b1, 32'h2222_2222, 1'b0, 2'd0};
    vecs[2] = '{4'h9,   32'h0,   32'h3333_3333, 5'd3, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 2'd0};
    vecs[3] = '{OP_LW,  32'h105, 32'h4444_4444, 5'd4, 1'b1, 1'b0, 32'h0,         1'b1, 2'd0};
    vecs[4] = '{OP_LH,  32'h101, 32'h5555_5555, 5'd5, 1'b1, 1'b0, 32'h0,         1'b1, 2'd0};
    vecs[5] = '{OP_SW,  32'h102, 32'h6666_6666, 5'd6, 1'b1, 1'b0, 32'h0,         1'b1, 2'd1};
    vecs[6] = '{OP_SH,  32'h203, 32'h7777_7777, 5'd7, 1'b1, 1'b0, 32'h0,         1'b1, 2'd1};
    vecs[7] = '{OP_LHU, 32'h0FF, 32'h8888_8888, 5'd8, 1'b1, 1'b0, 32'h0,         1'b1, 2'd0};

    // Reset state
    #12;
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset exc_valid", 32'(exc_valid), 32'd0);
    chk("reset halt", 32'(halt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset stall", 32'(stall), 32'd0);

    // Back-to-back single-cycle vectors
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      mem_op    = vecs[i].op;
      mem_addr  = vecs[i].addr;
      mem_data  = 32'h0;
      waddr_in  = vecs[i].wa;
      wdata_in  = vecs[i].alu;
      we_in     = vecs[i].we;
      tick();
      chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("vec%0d waddr", i), 32'(waddr_out), 32'(vecs[i].wa));
      chk($sformatf("vec%0d we", i), 32'(we_out), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d wdata", i), wdata_out, vecs[i].exp_wdata);
      chk($sformatf("vec%0d exc_valid", i), 32'(exc_valid), 32'(vecs[i].exp_exc));
      if (vecs[i].exp_exc) begin
        chk($sformatf("vec%0d exc_cause", i), 32'(exc_cause), 32'(vecs[i].exp_cause));
        chk($sformatf("vec%0d exc_addr", i), exc_addr, vecs[i].addr);
      end
      chk($sformatf("vec%0d bus_req", i), 32'(bus_req), 32'd0);
      chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;
    tick();
    chk("idle wb_valid pulse", 32'(wb_valid), 32'd0);
    chk("idle exc_valid pulse", 32'(exc_valid), 32'd0);

    // LB 0x103, ack on the third bus cycle
    issue(OP_LB, 32'h103, 32'h0, 5'd5);
    chk("lb bus_req", 32'(bus_req), 32'd1);
    chk("lb bus_addr", bus_addr, 32'h100);
    chk("lb stall c1", 32'(stall), 32'd1);
    chk("lb ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1;  // ignored while the bus cycle is open
    mem_op = OP_NOP;
    tick();
    chk("lb stall c2", 32'(stall), 32'd1);
    chk("lb wb during bus", 32'(wb_valid), 32'd0);
    tick();
    chk("lb stall c3", 32'(stall), 32'd1);
    req_valid = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h80FF_1234;
    tick();
    bus_ack = 1'b0;
    chk("lb wb_valid", 32'(wb_valid), 32'd1);
    chk("lb wdata", wdata_out, 32'hFFFF_FF80);
    chk("lb waddr", 32'(waddr_out), 32'd5);
    chk("lb we", 32'(we_out), 32'd1);
    chk("lb bus_req end", 32'(bus_req), 32'd0);
    chk("lb stall end", 32'(stall), 32'd0);

    // SH 0x202, immediate ack
    issue(OP_SH, 32'h202, 32'h0000_ABCD, 5'd6);
    chk("sh bus_be", 32'(bus_be), 32'hC);
    chk("sh bus_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh bus_we", 32'(bus_we), 32'd1);
    chk("sh bus_addr", bus_addr, 32'h200);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("sh wb_valid", 32'(wb_valid), 32'd1);
    chk("sh we", 32'(we_out), 32'd0);
    chk("sh exc_valid", 32'(exc_valid), 32'd0);

    // SB 0x101
    issue(OP_SB, 32'h101, 32'h1234_565A, 5'd7);
    chk("sb bus_be", 32'(bus_be), 32'h2);
    chk("sb bus_wdata", bus_wdata, 32'h5A5A_5A5A);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("sb we", 32'(we_out), 32'd0);

    do_load(OP_LHU, 32'h102, 32'h8765_4321, 32'h0000_8765, "lhu");
    do_load(OP_LH,  32'h100, 32'h0000_F00D, 32'hFFFF_F00D, "lh");
    do_load(OP_LBU, 32'h101, 32'h0000_9A00, 32'h0000_009A, "lbu");
    do_load(OP_LW,  32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");

    // Timeout: no response, request must last exactly 4 cycles
    issue(OP_LW, 32'h108, 32'h0, 5'd10);
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_req) break;
      n_req++;
      tick();
    end
    chk("tmo req cycles", 32'(n_req), 32'd4);
    chk("tmo exc_valid", 32'(exc_valid), 32'd1);
    chk("tmo exc_cause", 32'(exc_cause), 32'd3);
    chk("tmo exc_addr", exc_addr, 32'h108);
    chk("tmo we", 32'(we_out), 32'd0);
    chk("tmo wb_valid", 32'(wb_valid), 32'd1);

    // err and ack together: error wins
    issue(OP_LW, 32'h10C, 32'h0, 5'd11);
    bus_ack = 1'b1;
    bus_err = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_err = 1'b0;
    chk("err exc_valid", 32'(exc_valid), 32'd1);
    chk("err exc_cause", 32'(exc_cause), 32'd2);
    chk("err exc_addr", exc_addr, 32'h10C);
    chk("err we", 32'(we_out), 32'd0);

    // Async reset in the middle of a bus cycle
    issue(OP_LW, 32'h110, 32'h0, 5'd12);
    chk("rst pre bus_req", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst bus_req drop", 32'(bus_req), 32'd0);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst after ready", 32'(req_ready), 32'd1);
    chk("rst after bus_req", 32'(bus_req), 32'd0);

    // SW to HALT_ADDR
`ifdef MEM_LSU_HALT_DETECT_EN
    exp_halt = 1'b1;
`else
    exp_halt = 1'b0;
`endif
    issue(OP_SW, 32'h0000_1000, 32'h0000_0001, 5'd0);
    chk("halt store be", 32'(bus_be), 32'hF);
    chk("halt pre", 32'(halt), 32'd0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("halt set", 32'(halt), 32'(exp_halt));
    tick();
    tick();
    chk("halt sticky", 32'(halt), 32'(exp_halt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
